// File: rtl/fft_stage_sequencer.sv
// Radix-2 in-place FFT butterfly sequencer: walks every stage of a
// bit-reversed-input transform, issues one butterfly descriptor per handshake,
// caps in-flight butterflies, and holds a barrier between stages until every
// issued butterfly of the previous stage has been written back.
module fft_stage_sequencer #(
    parameter int unsigned SAMPLES         = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic                                   abort,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   bf_valid,
    input  logic                                   bf_ready,
    output logic [$clog2(SAMPLES)-1:0]             bf_idx_a,
    output logic [$clog2(SAMPLES)-1:0]             bf_idx_b,
    output logic [$clog2(SAMPLES)-2:0]             bf_twiddle,
    output logic [$clog2($clog2(SAMPLES))-1:0]     bf_stage,
    output logic                                   bf_last,
    input  logic                                   wb_ack
);

    localparam int unsigned LOG2 = $clog2(SAMPLES);
    localparam int unsigned BW   = LOG2 - 1;
    localparam int unsigned SW   = $clog2(LOG2);
    localparam int unsigned OW   = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [BW-1:0] B_LAST  = BW'(SAMPLES / 2 - 1);
    localparam logic [SW-1:0] S_LAST  = SW'(LOG2 - 1);
    localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_BARRIER = 2'd2;
    localparam logic [1:0] ST_FINISH  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [BW-1:0]   cnt_q, cnt_d;
    logic [OW-1:0]   out_q, out_d;
    logic            xfer;
    logic            ack_ok;
    logic            show_desc;

    logic            busy_d, done_d, valid_d, last_d;
    logic [LOG2-1:0] idx_a_d, idx_b_d;
    logic [BW-1:0]   twiddle_d;
    logic [SW-1:0]   stage_out_d;

    // Upper operand index: group base (grp << (s+1)) plus position in group.
    function automatic logic [LOG2-1:0] calc_idx_a(input logic [SW-1:0] st,
                                                   input logic [BW-1:0] bi);
        logic [LOG2-1:0] be;
        logic [LOG2-1:0] mask;
        be   = LOG2'(bi);
        mask = (LOG2'(1) << st) - LOG2'(1);
        return (((be >> st) << st) << 1) | (be & mask);
    endfunction

    // Twiddle index: position within the group scaled to the full ROM range.
    function automatic logic [BW-1:0] calc_twiddle(input logic [SW-1:0] st,
                                                   input logic [BW-1:0] bi);
        logic [BW-1:0] mask;
        mask = (BW'(1) << st) - BW'(1);
        return (bi & mask) << (S_LAST - st);
    endfunction

    // State and counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    // Next-state, counter and next-output logic.
    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        xfer        = bf_valid && bf_ready;
        ack_ok      = wb_ack && (out_q != '0);
        show_desc   = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        valid_d     = 1'b0;
        last_d      = 1'b0;
        idx_a_d     = '0;
        idx_b_d     = '0;
        twiddle_d   = '0;
        stage_out_d = '0;

        if (xfer && !ack_ok) begin
            out_d = out_q + OW'(1);
        end else if (!xfer && ack_ok) begin
            out_d = out_q - OW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    stage_d = '0;
                    cnt_d   = '0;
                end
            end
            ST_ISSUE: begin
                if (xfer) begin
                    cnt_d = cnt_q + BW'(1);
                    if (bf_last) begin
                        state_d = ST_BARRIER;
                    end
                end
            end
            ST_BARRIER: begin
                if (out_q == '0) begin
                    if (stage_q == S_LAST) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_ISSUE;
                        stage_d = stage_q + SW'(1);
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                stage_d = '0;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            stage_d = '0;
            cnt_d   = '0;
            out_d   = '0;
        end

        show_desc = (state_d == ST_ISSUE) || (state_d == ST_BARRIER);
        busy_d    = show_desc;
        done_d    = (state_d == ST_FINISH);
        valid_d   = (state_d == ST_ISSUE) && (out_d < OUT_MAX);
        last_d    = (state_d == ST_ISSUE) && (cnt_d == B_LAST);
        if (show_desc) begin
            idx_a_d     = calc_idx_a(stage_d, cnt_d);
            idx_b_d     = idx_a_d | (LOG2'(1) << stage_d);
            twiddle_d   = calc_twiddle(stage_d, cnt_d);
            stage_out_d = stage_d;
        end
    end

    // Registered outputs; descriptor only moves when (stage, count) moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            bf_valid   <= 1'b0;
            bf_last    <= 1'b0;
            bf_idx_a   <= '0;
            bf_idx_b   <= '0;
            bf_twiddle <= '0;
            bf_stage   <= '0;
        end else begin
            busy       <= busy_d;
            done       <= done_d;
            bf_valid   <= valid_d;
            bf_last    <= last_d;
            bf_idx_a   <= idx_a_d;
            bf_idx_b   <= idx_b_d;
            bf_twiddle <= twiddle_d;
            bf_stage   <= stage_out_d;
        end
    end

endmodule
